// File: rtl/sync_unified_memory.sv
// Clocked, byte-addressed big-endian memory shared by an instruction fetch port and
// a data load/store port with configurable wait-state latency and fault detection.
module sync_unified_memory #(
    parameter int ADDR_WIDTH = 20,
    parameter int LATENCY    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] InstAddr,
    input  logic        InstReq,
    output logic [31:0] ReadInst,
    output logic        InstValid,
    input  logic [31:0] DataAddr,
    input  logic [31:0] WriteData,
    input  logic        ReadMem,
    input  logic        WriteMem,
    input  logic [1:0]  DataSize,
    input  logic        DataSigned,
    output logic        DataBusy,
    output logic        DataReady,
    output logic [31:0] ReadData,
    output logic        DataError
);
    localparam int         WORDS  = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_size;
    logic                  r_signed, r_rd, r_wr;
    logic                  r_ready, r_err, r_ivalid;
    logic [31:0]           r_rdata, r_inst;

    logic                  w_accept, w_complete, w_fault, w_we;
    logic [ADDR_WIDTH-1:0] w_c_addr;
    logic [31:0]           w_c_wdata;
    logic [1:0]            w_c_size;
    logic                  w_c_signed, w_c_rd, w_c_wr;
    logic [3:0]            w_be;
    logic [31:0]           w_lane_data, w_load_word, w_load_val, w_inst_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [ADDR_WIDTH-3:0] w_d_idx, w_i_idx;
    logic                  w_unused;

    // Never-written bytes read as zero; contents survive Reset.
    logic [31:0] r_mem [WORDS] = '{default: 32'h0};

    assign w_unused = ^{DataAddr[31:ADDR_WIDTH], InstAddr[31:ADDR_WIDTH], InstAddr[1:0]};

    assign w_accept   = (r_state == S_IDLE) && (ReadMem || WriteMem);
    assign w_complete = (LATENCY == 1) ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With single-cycle latency the access completes on the accepting edge from live inputs.
    assign w_c_addr   = (LATENCY == 1) ? DataAddr[ADDR_WIDTH-1:0] : r_addr;
    assign w_c_wdata  = (LATENCY == 1) ? WriteData  : r_wdata;
    assign w_c_size   = (LATENCY == 1) ? DataSize   : r_size;
    assign w_c_signed = (LATENCY == 1) ? DataSigned : r_signed;
    assign w_c_rd     = (LATENCY == 1) ? ReadMem    : r_rd;
    assign w_c_wr     = (LATENCY == 1) ? WriteMem   : r_wr;

    assign w_d_idx = w_c_addr[ADDR_WIDTH-1:2];
    assign w_i_idx = InstAddr[ADDR_WIDTH-1:2];

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: if (w_accept && (LATENCY > 1)) begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = LAT_M1;
            end
            S_WAIT: if (r_cnt == 4'd1) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
        end else if (w_accept) begin
            r_addr   <= DataAddr[ADDR_WIDTH-1:0];
            r_wdata  <= WriteData;
            r_size   <= DataSize;
            r_signed <= DataSigned;
            r_rd     <= ReadMem;
            r_wr     <= WriteMem;
        end
    end

    always_comb begin
        w_fault     = 1'b0;
        w_be        = 4'b1111;
        w_lane_data = w_c_wdata;
        case (w_c_size)
            SZ_BYTE: begin
                w_be        = 4'b1000 >> w_c_addr[1:0];
                w_lane_data = {4{w_c_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_fault     = w_c_addr[0];
                w_be        = w_c_addr[1] ? 4'b0011 : 4'b1100;
                w_lane_data = {2{w_c_wdata[15:0]}};
            end
            SZ_WORD: w_fault = |w_c_addr[1:0];
            default: w_fault = 1'b1;
        endcase
        if (w_c_rd && w_c_wr) w_fault = 1'b1;
    end

    assign w_we = w_complete && w_c_wr && !w_fault && !Reset;

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++)
            if (w_we && w_be[i]) r_mem[w_d_idx][i*8 +: 8] <= w_lane_data[i*8 +: 8];
    end

    // Lane 3 holds the lowest byte address (big-endian).
    function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic hit,
                                                input logic [3:0] be, input logic [31:0] data);
        merge_store = old_word;
        for (int i = 0; i < 4; i++)
            if (hit && be[i]) merge_store[i*8 +: 8] = data[i*8 +: 8];
    endfunction

    assign w_inst_word = merge_store(r_mem[w_i_idx], w_we && (w_i_idx == w_d_idx), w_be, w_lane_data);
    assign w_load_word = r_mem[w_d_idx];
    assign w_byte      = w_load_word[{~w_c_addr[1:0], 3'b000} +: 8];
    assign w_half      = w_c_addr[1] ? w_load_word[15:0] : w_load_word[31:16];

    always_comb begin
        w_load_val = w_load_word;
        if (w_c_size == SZ_BYTE)      w_load_val = {{24{w_c_signed & w_byte[7]}}, w_byte};
        else if (w_c_size == SZ_HALF) w_load_val = {{16{w_c_signed & w_half[15]}}, w_half};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_ivalid <= 1'b0;
            r_inst   <= '0;
        end else begin
            r_ready  <= w_complete;
            r_ivalid <= InstReq;
            if (w_complete) begin
                r_err   <= w_fault;
                r_rdata <= (w_fault || !w_c_rd) ? 32'h0 : w_load_val;
            end
            if (InstReq) r_inst <= w_inst_word;
        end
    end

    assign DataBusy  = (r_state == S_WAIT);
    assign DataReady = r_ready;
    assign DataError = r_err;
    assign ReadData  = r_rdata;
    assign InstValid = r_ivalid;
    assign ReadInst  = r_inst;
endmodule

// File: tb/tb_sync_unified_memory.sv
// Scoreboard bench: three instances (LATENCY 3, 1, 4); expected data-port results are queued
// at request time and retired by a monitor whenever an instance pulses DataReady.
module tb_sync_unified_memory;
    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst         [3];
    logic [31:0] inst_addr   [3];
    logic        inst_req    [3];
    logic [31:0] read_inst   [3];
    logic        inst_valid  [3];
    logic [31:0] data_addr   [3];
    logic [31:0] write_data  [3];
    logic        read_mem    [3];
    logic        write_mem   [3];
    logic [1:0]  data_size   [3];
    logic        data_signed [3];
    logic        data_busy   [3];
    logic        data_ready  [3];
    logic [31:0] read_data   [3];
    logic        data_error  [3];

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sync_unified_memory #(
            .ADDR_WIDTH(20),
            .LATENCY   (g == 0 ? 3 : (g == 1 ? 1 : 4))
        ) u_dut (
            .Clk       (clk),
            .Reset     (rst[g]),
            .InstAddr  (inst_addr[g]),
            .InstReq   (inst_req[g]),
            .ReadInst  (read_inst[g]),
            .InstValid (inst_valid[g]),
            .DataAddr  (data_addr[g]),
            .WriteData (write_data[g]),
            .ReadMem   (read_mem[g]),
            .WriteMem  (write_mem[g]),
            .DataSize  (data_size[g]),
            .DataSigned(data_signed[g]),
            .DataBusy  (data_busy[g]),
            .DataReady (data_ready[g]),
            .ReadData  (read_data[g]),
            .DataError (data_error[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : 4);
    endfunction

    // Scoreboard monitor: every completion pulse retires the oldest expected result.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (data_ready[d] === 1'b1 && rst[d] === 1'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_ready dut%0d: got DataReady=1 want no completion", d);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.dut != d)
                        $display("FAIL %s order: completed on dut%0d want dut%0d", mon_e.name, d, mon_e.dut);
                    else n_pass++;
                    n_checks++;
                    if (read_data[d] !== mon_e.rdata)
                        $display("FAIL %s rdata: got %h want %h", mon_e.name, read_data[d], mon_e.rdata);
                    else n_pass++;
                    n_checks++;
                    if (data_error[d] !== mon_e.err)
                        $display("FAIL %s err: got %b want %b", mon_e.name, data_error[d], mon_e.err);
                    else n_pass++;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs(input int d);
        inst_addr[d]   = '0;
        inst_req[d]    = 1'b0;
        data_addr[d]   = '0;
        write_data[d]  = '0;
        read_mem[d]    = 1'b0;
        write_mem[d]   = 1'b0;
        data_size[d]   = 2'b00;
        data_signed[d] = 1'b0;
    endtask

    // Issues one request, queues its expected result and checks latency, busy span and pulse width.
    task automatic access(input int d, input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                          input logic sgn, input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   cycles;
        int   busy_n;
        @(negedge clk);
        read_mem[d]    = rd;
        write_mem[d]   = wr;
        data_addr[d]   = addr;
        write_data[d]  = wdata;
        data_size[d]   = size;
        data_signed[d] = sgn;
        e.dut = d; e.rdata = exp_rdata; e.err = exp_err; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        read_mem[d]  = 1'b0;
        write_mem[d] = 1'b0;
        cycles = 1;
        busy_n = 0;
        while (data_ready[d] !== 1'b1 && cycles < 32) begin
            if (data_busy[d] === 1'b1) busy_n++;
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (data_ready[d] !== 1'b1) begin
            $display("FAIL %s timeout: no DataReady after %0d cycles", name, cycles);
            if (sb.size() != 0) void'(sb.pop_back());
        end else begin
            n_pass++;
            n_checks++;
            if (cycles != lat_of(d)) $display("FAIL %s latency: got %0d want %0d", name, cycles, lat_of(d));
            else n_pass++;
            n_checks++;
            if (busy_n != lat_of(d) - 1) $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_n, lat_of(d) - 1);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (data_ready[d] !== 1'b0) $display("FAIL %s pulse_width: got DataReady=%b want 0", name, data_ready[d]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            idle_inputs(d);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({data_ready[d], data_busy[d], data_error[d], inst_valid[d]} !== 4'b0000)
                $display("FAIL reset_flags dut%0d: got %b want 0000", d,
                         {data_ready[d], data_busy[d], data_error[d], inst_valid[d]});
            else n_pass++;
            n_checks++;
            if ({read_data[d], read_inst[d]} !== 64'h0)
                $display("FAIL reset_data dut%0d: got %h want 0", d, {read_data[d], read_inst[d]});
            else n_pass++;
            rst[d] = 1'b0;
        end
    endtask

    task automatic test_load_store_l3();
        access(0, "st_w_100",   1'b0, 1'b1, 32'h100, 32'h11223344, 2'b10, 1'b0, 32'h0,        1'b0);
        access(0, "ld_w_100",   1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h11223344, 1'b0);
        access(0, "ld_bs_101",  1'b1, 1'b0, 32'h101, 32'h0,        2'b00, 1'b1, 32'h00000022, 1'b0);
        access(0, "st_h_102",   1'b0, 1'b1, 32'h102, 32'h0000FF80, 2'b01, 1'b0, 32'h0,        1'b0);
        access(0, "ld_hs_102",  1'b1, 1'b0, 32'h102, 32'h0,        2'b01, 1'b1, 32'hFFFFFF80, 1'b0);
        access(0, "ld_hu_102",  1'b1, 1'b0, 32'h102, 32'h0,        2'b01, 1'b0, 32'h0000FF80, 1'b0);
        access(0, "ld_bs_103",  1'b1, 1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
        access(0, "ld_bu_102",  1'b1, 1'b0, 32'h102, 32'h0,        2'b00, 1'b0, 32'h000000FF, 1'b0);
        access(0, "ld_w_merge", 1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h1122FF80, 1'b0);
    endtask

    task automatic test_faults();
        access(0, "flt_ld_w_102", 1'b1, 1'b0, 32'h102, 32'h0,        2'b10, 1'b0, 32'h0, 1'b1);
        access(0, "flt_ld_h_103", 1'b1, 1'b0, 32'h103, 32'h0,        2'b01, 1'b1, 32'h0, 1'b1);
        access(0, "flt_size11",   1'b1, 1'b0, 32'h100, 32'h0,        2'b11, 1'b0, 32'h0, 1'b1);
        access(0, "flt_rdwr_200", 1'b1, 1'b1, 32'h200, 32'hAABBCCDD, 2'b10, 1'b0, 32'h0, 1'b1);
        access(0, "flt_st_h_103", 1'b0, 1'b1, 32'h103, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b1);
        access(0, "ld_w_200",     1'b1, 1'b0, 32'h200, 32'h0,        2'b10, 1'b0, 32'h0, 1'b0);
        access(0, "ld_w_100_kept",1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h1122FF80, 1'b0);
    endtask

    task automatic test_bypass_l1();
        exp_t e;
        @(negedge clk);
        write_mem[1]  = 1'b1;
        data_addr[1]  = 32'h40;
        write_data[1] = 32'hDEADBEEF;
        data_size[1]  = 2'b10;
        inst_req[1]   = 1'b1;
        inst_addr[1]  = 32'h40;
        e.dut = 1; e.rdata = 32'h0; e.err = 1'b0; e.name = "bypass_st_40";
        sb.push_back(e);
        @(negedge clk);
        write_mem[1] = 1'b0;
        inst_req[1]  = 1'b0;
        n_checks++;
        if (data_ready[1] !== 1'b1) $display("FAIL bypass_ready: got %b want 1", data_ready[1]);
        else n_pass++;
        n_checks++;
        if (inst_valid[1] !== 1'b1) $display("FAIL bypass_ivalid: got %b want 1", inst_valid[1]);
        else n_pass++;
        n_checks++;
        if (read_inst[1] !== 32'hDEADBEEF) $display("FAIL bypass_inst: got %h want deadbeef", read_inst[1]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (inst_valid[1] !== 1'b0 || read_inst[1] !== 32'hDEADBEEF)
            $display("FAIL fetch_hold: got valid=%b inst=%h want valid=0 inst=deadbeef", inst_valid[1], read_inst[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h40, 32'h44, 32'h48, 32'h41};
        logic [1:0]  sizes [4] = '{2'b10, 2'b10, 2'b10, 2'b00};
        logic [31:0] exps  [4] = '{32'hDEADBEEF, 32'h01020304, 32'hA5A55A5A, 32'h000000AD};
        exp_t e;
        access(1, "st_w_44", 1'b0, 1'b1, 32'h44, 32'h01020304, 2'b10, 1'b0, 32'h0, 1'b0);
        access(1, "st_w_48", 1'b0, 1'b1, 32'h48, 32'hA5A55A5A, 2'b10, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (data_ready[1] !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i - 1, data_ready[1]);
                else n_pass++;
            end
            if (i < 4) begin
                read_mem[1]  = 1'b1;
                data_addr[1] = addrs[i];
                data_size[1] = sizes[i];
                e.dut = 1; e.rdata = exps[i]; e.err = 1'b0; e.name = $sformatf("b2b_ld_%0d", i);
                sb.push_back(e);
            end else begin
                read_mem[1] = 1'b0;
            end
        end
    endtask

    task automatic test_fetch();
        logic [31:0] addrs [3] = '{32'h8000, 32'h00100040, 32'h43};
        logic [31:0] exps  [3] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inst_req[1]  = 1'b1;
            inst_addr[1] = addrs[i];
            @(negedge clk);
            inst_req[1] = 1'b0;
            n_checks++;
            if (inst_valid[1] !== 1'b1 || read_inst[1] !== exps[i])
                $display("FAIL fetch_%h: got valid=%b inst=%h want valid=1 inst=%h",
                         addrs[i], inst_valid[1], read_inst[1], exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort_l4();
        int late_ready;
        access(2, "l4_st_304", 1'b0, 1'b1, 32'h304, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0);
        access(2, "l4_ld_304", 1'b1, 1'b0, 32'h304, 32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0);
        @(negedge clk);
        inst_req[2]  = 1'b1;
        inst_addr[2] = 32'h304;
        @(negedge clk);
        inst_req[2]    = 1'b0;
        write_mem[2]   = 1'b1;
        data_addr[2]   = 32'h300;
        write_data[2]  = 32'hCAFEF00D;
        data_size[2]   = 2'b10;
        @(negedge clk);
        write_mem[2] = 1'b0;
        n_checks++;
        if (data_busy[2] !== 1'b1 || read_inst[2] !== 32'h12345678)
            $display("FAIL abort_pre: got busy=%b inst=%h want busy=1 inst=12345678", data_busy[2], read_inst[2]);
        else n_pass++;
        rst[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({data_ready[2], data_busy[2], data_error[2], inst_valid[2]} !== 4'b0000 ||
            {read_data[2], read_inst[2]} !== 64'h0)
            $display("FAIL abort_reset_outputs: got flags=%b data=%h inst=%h want all 0",
                     {data_ready[2], data_busy[2], data_error[2], inst_valid[2]}, read_data[2], read_inst[2]);
        else n_pass++;
        rst[2] = 1'b0;
        late_ready = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_ready[2] === 1'b1 || data_busy[2] === 1'b1) late_ready++;
        end
        n_checks++;
        if (late_ready != 0) $display("FAIL abort_dropped: got %0d active cycles want 0", late_ready);
        else n_pass++;
        access(2, "l4_ld_300", 1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 32'h0,        1'b0);
        access(2, "l4_ld_304_kept", 1'b1, 1'b0, 32'h304, 32'h0, 2'b10, 1'b0, 32'h12345678, 1'b0);
    endtask

    initial begin
        test_reset();
        test_load_store_l3();
        test_faults();
        test_bypass_l1();
        test_back_to_back();
        test_fetch();
        test_reset_abort_l4();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sync_unified_memory.md
# sync_unified_memory

Parametrised, clocked successor to the combinational unified instruction/data memory. It holds one byte-addressed, big-endian memory shared by an instruction fetch port and a data load/store port. The data port supports byte, halfword and word accesses with sign/zero extension, a configurable wait-state latency and misalignment detection. It sits between the pipelined CPU core and its fetch and memory stages, and replaces the zero-latency model for multi-cycle-memory experiments.

## Interface
- ADDR_WIDTH, 20, byte-address bits used; memory depth is 2**ADDR_WIDTH bytes; address bits above it are ignored (wrap).
- LATENCY, 1, data-port cycles from request acceptance to DataReady; legal range 1..15.
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InstAddr  input  32  fetch byte address; bits [1:0] ignored (word fetch).
- InstReq  input  1  fetch request, sampled every edge.
- ReadInst  output  32  fetched word, big-endian (Mem[a] in [31:24]).
- InstValid  output  1  ReadInst valid this cycle.
- DataAddr  input  32  load/store byte address.
- WriteData  input  32  store data, right-aligned for byte/half.
- ReadMem  input  1  load request.
- WriteMem  input  1  store request.
- DataSize  input  2  00 byte, 01 half, 10 word, 11 reserved.
- DataSigned  input  1  sign-extend byte/half loads when 1, zero-extend when 0.
- DataBusy  output  1  request outstanding; new requests ignored.
- DataReady  output  1  one-cycle completion pulse.
- ReadData  output  32  load result, valid while DataReady.
- DataError  output  1  access faulted, valid while DataReady.

## Operation
- Data FSM states: IDLE, WAIT.
- Acceptance:
  - A request (ReadMem|WriteMem) is accepted at an edge where the FSM is IDLE and Reset=0.
  - Address, data, size, signedness and direction are captured at that edge.
- IDLE -> WAIT on acceptance when LATENCY>1. The wait counter loads LATENCY-1 and decrements per edge.
- WAIT -> IDLE when the counter reaches 1. At that same edge the access completes.
- LATENCY=1: the FSM stays in IDLE and the access completes at the accepting edge.
- Completion edge:
  - Store bytes are written.
  - ReadData/DataError are registered.
  - DataReady rises for exactly one cycle.
- Fault, raised at completion:
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - DataSize=11.
  - ReadMem and WriteMem both high.
  - On fault: DataError=1, ReadData=0, no bytes written.
- Stores:
  - Byte: WriteData[7:0] goes to Mem[a].
  - Half: [15:8] to Mem[a], [7:0] to Mem[a+1].
  - Word: [31:24]..[7:0] to Mem[a]..Mem[a+3].
- Loads:
  - Byte: Mem[a] is extended to 32 bits.
  - Half: {Mem[a],Mem[a+1]} is extended.
  - Word: {Mem[a]..Mem[a+3]}.
  - ReadData is 0 on a store completion.
- Fetch: InstReq sampled high at an edge registers the word at {InstAddr[ADDR_WIDTH-1:2],2'b00} into ReadInst, and InstValid=1 the next cycle. InstReq low leaves ReadInst holding and InstValid=0.
- Write-first bypass: a fetch or load sampled at the same edge as a store completion sees the newly written bytes in every overlapping byte lane.
- Memory contents:
  - Memory is zero at simulation start; never-written bytes read as 0, not X.
  - Reset does not clear memory contents.

## Timing
- Reset values: ReadInst=0, InstValid=0, ReadData=0, DataReady=0, DataError=0, DataBusy=0, FSM=IDLE, counter=0.
- Reset dominates every other input. An outstanding request is dropped, and its store is never committed.
- Data port:
  - Request accepted at edge k gives DataReady high in the cycle after edge k+LATENCY-1.
  - DataBusy is high from edge k until that completion edge when LATENCY>1, and always 0 when LATENCY=1.
- The DataReady cycle has the FSM in IDLE, so a new request can be accepted at the edge ending it. Peak throughput is one access per LATENCY cycles.
- Requests presented while DataBusy=1 are ignored. They are not queued, and the requester holds them until acceptance.
- Fetch latency is 1 cycle, with one fetch per cycle, independent of data-port state.

## Test plan
- Reset with LATENCY=3; store word 0x11223344 to 0x100; load word 0x100 -> DataBusy high 2 cycles each, DataReady 3 cycles after acceptance, ReadData=0x11223344, DataError=0.
- After that store: load byte 0x101 signed -> 0x00000022; store half 0xFF80 to 0x102; load half 0x102 signed -> 0xFFFFFF80; unsigned -> 0x0000FF80.
- Word load at 0x102, half load at 0x103, DataSize=11, ReadMem&WriteMem at 0x200 -> each gives DataError=1, ReadData=0; later load of 0x200 returns 0.
- LATENCY=1: store 0xDEADBEEF to 0x40 with InstReq=1 and InstAddr=0x40 at the same edge -> next cycle ReadInst=0xDEADBEEF, InstValid=1; back-to-back loads complete every cycle.
- Fetch unwritten 0x8000 -> ReadInst=0; address 0x00100040 with ADDR_WIDTH=20 aliases to 0x40.
- LATENCY=4: accept store to 0x300, assert Reset one cycle later -> all outputs 0, no DataReady; load 0x300 -> 0.
